mem_stage_p: RTL

Parametrised LEGv8 memory pipeline stage: EX/MEM register, byte-addressable data memory, and branch resolution in one block. Sits between execute and write-back. Extends the fixed 64-bit, single-cycle memory stage with:
- configurable word width, memory depth and wait states;
- sub-word loads/stores with sign/zero extension;
- CBNZ resolution, misalignment detection, and a valid/ready stall handshake toward execute.

---
 rtl/mem_stage_p_pkg.sv | 30 +++
 rtl/mem_stage_p_data_mem_bank.sv | 22 ++
 rtl/mem_stage_p.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_stage_p_pkg.sv
// mem_stage_p_pkg: shared size/state encodings, control bundle and alignment helper
package mem_stage_p_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {ST_RUN, ST_HOLD} state_e;

    typedef struct packed {
        logic       uncond;
        logic       branch;
        logic       branch_nz;
        logic       zero;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] size;
        logic       sgn;
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] rd;
    } ctrl_t;

    // A double has no natural alignment on a 32-bit datapath, so it is always flagged.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size, input logic w32);
        return (|(off & ((3'd1 << size) - 3'd1))) || (w32 && size == SZ_D);
    endfunction

endpackage

// File: rtl/mem_stage_p_data_mem_bank.sv
// data_mem_bank: DEPTH x WORD memory, per-byte write enables, asynchronous read, contents never reset
module data_mem_bank #(
    parameter int WORD  = 64,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [WORD/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD-1:0]          wdata,
    output logic [WORD-1:0]          rdata
);

    logic [WORD-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        for (int i = 0; i < WORD/8; i++)
            if (we && be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_p.sv
// mem_stage_p: EX/MEM register, byte-addressable data memory with wait states, and branch resolution
module mem_stage_p
    import mem_stage_p_pkg::*;
#(
    parameter int WORD  = 64,
    parameter int DEPTH = 256,
    parameter int WAIT  = 0
) (
    input  logic            im_clk,
    input  logic            im_rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] pc_in,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] read_data2,
    input  logic            uncond_branch,
    input  logic            branch,
    input  logic            branch_nz,
    input  logic            zero,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      mem_size,
    input  logic            mem_signed,
    input  logic            mem_to_reg_in,
    input  logic            reg_write_in,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    output logic [WORD-1:0] pc_out,
    output logic [WORD-1:0] alu_result_out,
    output logic [WORD-1:0] read_data,
    output logic            mem_to_reg_out,
    output logic            reg_write_out,
    output logic [4:0]      rd_out,
    output logic            pc_src,
    output logic            misalign
);

    localparam int OB = $clog2(WORD/8);
    localparam int AB = $clog2(DEPTH);
    localparam int NB = WORD/8;

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic            valid_q;
    logic [WORD-1:0] pc_q, alu_q, wd_q;
    ctrl_t           c_q, c_in;
    logic            hold_in, we, sign, unused_hi;
    logic [NB-1:0]   be;
    logic [OB+2:0]   bsh;
    logic [WORD-1:0] wdata, rword, sh, keep, ld;

    assign c_in = '{uncond_branch, branch, branch_nz, zero, mem_read, mem_write,
                    mem_size, mem_signed, mem_to_reg_in, reg_write_in, rd_in};
    assign hold_in = (mem_read | mem_write) &&
                     !misaligned(3'(alu_result[OB-1:0]), mem_size, WORD == 32);

    always_ff @(posedge im_clk or negedge im_rst_n) begin
        if (!im_rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            alu_q   <= '0;
            wd_q    <= '0;
            c_q     <= '0;
        end else if (state_q == ST_RUN) begin
            valid_q <= in_valid;
            if (in_valid) begin
                pc_q  <= pc_in;
                alu_q <= alu_result;
                wd_q  <= read_data2;
                c_q   <= c_in;
                if (WAIT > 0 && hold_in) begin
                    state_q <= ST_HOLD;
                    cnt_q   <= 3'(WAIT);
                end
            end
        end else begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_q <= ST_RUN;
        end
    end

    assign in_ready       = state_q == ST_RUN;
    assign out_valid      = valid_q && in_ready;
    assign misalign       = out_valid && (c_q.mem_read | c_q.mem_write) &&
                            misaligned(3'(alu_q[OB-1:0]), c_q.size, WORD == 32);
    assign pc_src         = out_valid && (c_q.uncond || (c_q.branch && c_q.zero) || (c_q.branch_nz && !c_q.zero));
    assign reg_write_out  = out_valid && c_q.reg_write && !misalign;
    assign mem_to_reg_out = c_q.mem_to_reg;
    assign rd_out         = c_q.rd;
    assign pc_out         = pc_q;
    assign alu_result_out = alu_q;
    assign unused_hi      = ^alu_q[WORD-1:OB+AB];

    // Bytes are little-endian within an entry; the offset selects the lane.
    assign bsh   = {alu_q[OB-1:0], 3'b000};
    assign be    = NB'(((9'd1 << (4'd1 << c_q.size)) - 9'd1) << alu_q[OB-1:0]);
    assign wdata = wd_q << bsh;
    assign we    = out_valid && c_q.mem_write && !misalign;

    data_mem_bank #(.WORD(WORD), .DEPTH(DEPTH)) u_bank (
        .clk  (im_clk),
        .we   (we),
        .be   (be),
        .addr (alu_q[OB +: AB]),
        .wdata(wdata),
        .rdata(rword)
    );

    // keep masks the loaded field; its top set bit is the sign position.
    assign sh        = rword >> bsh;
    assign keep      = ~({WORD{1'b1}} << (7'd8 << c_q.size));
    assign sign      = c_q.sgn && |(sh & keep & ~(keep >> 1));
    assign ld        = (sh & keep) | (sign ? ~keep : '0);
    assign read_data = (out_valid && c_q.mem_read && !c_q.mem_write && !misalign) ? ld : '0;

endmodule
